ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, fed from the ID/EX pipeline register outputs (op3, i, valA, valB, imm13, rd). It executes SPARC V8 UMUL, SMUL, UDIV and SDIV over multiple cycles. While it runs, it raises `busy` so hazard control stalls IF/ID/IDEX. On completion it returns the 32-bit result and the Y-register update to the EX/MEM path.

---
 rtl/sparc_pkg.sv | 21 ++
 rtl/ex_muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_pkg.sv
// Shared SPARC EX-stage definitions: mul/div op3 codes, multiply/divide FSM states,
// and the simm13 sign-extension helper.
package sparc_pkg;

  localparam logic [5:0] OP3_UMUL = 6'h0A;
  localparam logic [5:0] OP3_SMUL = 6'h0B;
  localparam logic [5:0] OP3_UDIV = 6'h0E;
  localparam logic [5:0] OP3_SDIV = 6'h0F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic [31:0] sext13(input logic [12:0] v);
    return {{19{v[12]}}, v};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit UMUL/SMUL/UDIV/SDIV unit for the EX stage. It takes one step per cycle
// over 32 cycles, then a sign/saturation fix-up cycle, then a one-cycle done pulse.
module ex_muldiv_unit
  import sparc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [5:0]            op3,
  input  logic                  i,
  input  logic [DATA_WIDTH-1:0] valA,
  input  logic [DATA_WIDTH-1:0] valB,
  input  logic [12:0]           imm13,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [4:0]            rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_we,
  output logic                  div_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] sat_udiv(input logic [W-1:0] q, input logic ovf);
    return ovf ? {W{1'b1}} : q;
  endfunction

  // q is the unsigned quotient magnitude; ovf means the magnitude did not fit in W bits.
  function automatic logic [W-1:0] sat_sdiv(input logic [W-1:0] q, input logic neg,
                                            input logic ovf);
    if (ovf)  return neg ? SMIN : SMAX;
    if (!neg) return q[W-1] ? SMAX : q;
    return (q > SMIN) ? SMIN : (-q);
  endfunction

  muldiv_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [W-1:0]  opb_q, opb_d;
  logic          is_div_q, is_div_d, is_sgn_q, is_sgn_d;
  logic          neg_q, neg_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [4:0]    rd_q, rd_d;
  logic [W-1:0]  result_q, result_d, y_out_q, y_out_d;
  logic [4:0]    rd_out_q, rd_out_d;
  logic          y_we_q, y_we_d, div_zero_q, div_zero_d, done_q, done_d;

  logic [W-1:0]  op2, a_mag, b_mag, div_diff;
  logic [W2-1:0] dividend, dd_mag, prod;
  logic [W:0]    mul_sum, div_trial;
  logic          legal, in_div, in_sgn, a_neg, b_neg, dd_neg, div_ge;

  always_comb begin
    op2       = i ? sext13(imm13) : valB;
    legal     = op3 inside {OP3_UMUL, OP3_SMUL, OP3_UDIV, OP3_SDIV};
    in_div    = op3[2];
    in_sgn    = op3[0];
    a_neg     = in_sgn & valA[W-1];
    b_neg     = in_sgn & op2[W-1];
    dd_neg    = in_sgn & y_in[W-1];
    dividend  = {y_in, valA};
    a_mag     = a_neg ? -valA : valA;
    b_mag     = b_neg ? -op2 : op2;
    dd_mag    = dd_neg ? -dividend : dividend;
    mul_sum   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    // Remainder stays below the divisor, so the W-bit difference is exact when taken.
    div_trial = {acc_q[W2-1:W], acc_q[W-1]};
    div_ge    = div_trial >= {1'b0, opb_q};
    div_diff  = div_trial[W-1:0] - opb_q;
    prod      = neg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    is_sgn_d   = is_sgn_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    rd_d       = rd_q;
    result_d   = result_q;
    y_out_d    = y_out_q;
    rd_out_d   = rd_out_q;
    y_we_d     = y_we_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && legal) begin
            state_d  = CALC;
            cnt_d    = 5'd31;
            acc_d    = in_div ? dd_mag : {{W{1'b0}}, a_mag};
            opb_d    = b_mag;
            is_div_d = in_div;
            is_sgn_d = in_sgn;
            neg_d    = in_div ? (dd_neg ^ b_neg) : (a_neg ^ b_neg);
            dz_d     = in_div && (op2 == '0);
            ovf_d    = in_div && (dd_mag[W2-1:W] >= b_mag);
            rd_d     = rd_in;
          end
        end
        CALC: begin
          acc_d = is_div_q ? {(div_ge ? div_diff : div_trial[W-1:0]), acc_q[W-2:0], div_ge}
                           : {mul_sum, acc_q[W-1:1]};
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = FIX;
        end
        FIX: begin
          state_d  = DONE;
          done_d   = 1'b1;
          rd_out_d = rd_q;
          if (is_div_q) begin
            y_we_d     = 1'b0;
            div_zero_d = dz_q;
            if (dz_q)          result_d = '0;
            else if (is_sgn_q) result_d = sat_sdiv(acc_q[W-1:0], neg_q, ovf_q);
            else               result_d = sat_udiv(acc_q[W-1:0], ovf_q);
          end else begin
            result_d   = prod[W-1:0];
            y_out_d    = prod[W2-1:W];
            y_we_d     = 1'b1;
            div_zero_d = 1'b0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      y_out_q    <= '0;
      rd_out_q   <= '0;
      y_we_q     <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      y_out_q    <= y_out_d;
      rd_out_q   <= rd_out_d;
      y_we_q     <= y_we_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  // Datapath state is always reloaded on start, so it carries no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opb_q    <= opb_d;
    is_div_q <= is_div_d;
    is_sgn_q <= is_sgn_d;
    neg_q    <= neg_d;
    ovf_q    <= ovf_d;
    dz_q     <= dz_d;
    rd_q     <= rd_d;
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = done_q;
  assign result   = result_q;
  assign y_out    = y_out_q;
  assign rd_out   = rd_out_q;
  assign y_we     = y_we_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, plus flush, async-reset and back-to-back sequences.
module tb_ex_muldiv_unit;

  localparam logic [5:0] UMUL = 6'h0A, SMUL = 6'h0B, UDIV = 6'h0E, SDIV = 6'h0F;

  logic        clk = 1'b0;
  logic        reset, start, flush, i;
  logic [5:0]  op3;
  logic [31:0] valA, valB, y_in;
  logic [12:0] imm13;
  logic [4:0]  rd_in;
  logic        busy, done, y_we, div_zero;
  logic [31:0] result, y_out;
  logic [4:0]  rd_out;

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op3(op3), .i(i),
    .valA(valA), .valB(valB), .imm13(imm13), .y_in(y_in), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .y_out(y_out),
    .y_we(y_we), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op3;
    logic        i;
    logic [31:0] a, b;
    logic [12:0] imm;
    logic [31:0] y;
    logic [4:0]  rd;
    logic [31:0] res, yo;
    logic        ywe, dz;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] y_hold;
  logic [31:0] last_res;
  vec_t        tbl[$];

  function automatic vec_t mk(input logic [5:0] o, input logic ii, input logic [31:0] a,
                              input logic [31:0] b, input logic [12:0] imm, input logic [31:0] y,
                              input logic [4:0] rd, input logic [31:0] res, input logic [31:0] yo,
                              input logic ywe, input logic dz);
    vec_t v;
    v.op3 = o; v.i = ii; v.a = a; v.b = b; v.imm = imm; v.y = y; v.rd = rd;
    v.res = res; v.yo = yo; v.ywe = ywe; v.dz = dz;
    return v;
  endfunction

  // Reference: plain 64/128-bit arithmetic, saturating the quotient to the 32-bit range.
  function automatic vec_t ref_model(input vec_t vin);
    vec_t v = vin;
    logic [31:0] op2;
    logic [63:0] up;
    logic signed [63:0] sa, sb, sp;
    logic signed [127:0] n, d, q;
    op2 = v.i ? {{19{v.imm[12]}}, v.imm} : v.b;
    v.yo = 32'h0; v.ywe = 1'b0; v.dz = 1'b0; v.res = 32'h0;
    case (v.op3)
      UMUL: begin
        up = {32'h0, v.a} * {32'h0, op2};
        v.res = up[31:0]; v.yo = up[63:32]; v.ywe = 1'b1;
      end
      SMUL: begin
        sa = {{32{v.a[31]}}, v.a};
        sb = {{32{op2[31]}}, op2};
        sp = sa * sb;
        v.res = sp[31:0]; v.yo = sp[63:32]; v.ywe = 1'b1;
      end
      UDIV: begin
        if (op2 == 0) v.dz = 1'b1;
        else if (v.y >= op2) v.res = 32'hFFFFFFFF;
        else begin
          up = {v.y, v.a} / {32'h0, op2};
          v.res = up[31:0];
        end
      end
      default: begin
        if (op2 == 0) v.dz = 1'b1;
        else begin
          n = {{64{v.y[31]}}, v.y, v.a};
          d = {{96{op2[31]}}, op2};
          q = n / d;
          if (q > 128'sd2147483647)       v.res = 32'h7FFFFFFF;
          else if (q < -128'sd2147483648) v.res = 32'h80000000;
          else                            v.res = q[31:0];
        end
      end
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic st);
    op3 = v.op3; i = v.i; valA = v.a; valB = v.b; imm13 = v.imm; y_in = v.y; rd_in = v.rd;
    start = st;
  endtask

  // Counts cycles (sampled on negedge) until done, bounded at 40.
  task automatic wait_done(output int lat, output int bc);
    lat = -1; bc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_outs(input string nm, input vec_t v);
    logic [31:0] ey;
    ey = v.ywe ? v.yo : y_hold;
    chk($sformatf("%s result", nm), result, v.res);
    chk($sformatf("%s y_out", nm), y_out, ey);
    chk($sformatf("%s y_we", nm), y_we, v.ywe);
    chk($sformatf("%s div_zero", nm), div_zero, v.dz);
    chk($sformatf("%s rd_out", nm), rd_out, v.rd);
    y_hold   = ey;
    last_res = v.res;
  endtask

  task automatic do_op(input string nm, input vec_t v);
    int lat, bc;
    apply(v, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    chk($sformatf("%s latency", nm), lat, 34);
    chk($sformatf("%s busy_cycles", nm), bc, 33);
    check_outs(nm, v);
    @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    chk($sformatf("%s busy", nm), busy, 0);
    chk($sformatf("%s done", nm), done, 0);
    chk($sformatf("%s result", nm), result, 0);
    chk($sformatf("%s y_out", nm), y_out, 0);
    chk($sformatf("%s rd_out", nm), rd_out, 0);
    chk($sformatf("%s y_we", nm), y_we, 0);
    chk($sformatf("%s div_zero", nm), div_zero, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat, bc, dseen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; i = 1'b0; op3 = '0;
    valA = '0; valB = '0; y_in = '0; imm13 = '0; rd_in = '0;
    y_hold = '0; last_res = '0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    //            op3   i  a             b             imm      y             rd     res           yo            ywe dz
    tbl.push_back(mk(UMUL, 0, 32'hFFFFFFFF, 32'h2,        13'h0,    32'h0,        5'd3,  32'hFFFFFFFE, 32'h1,        1, 0));
    tbl.push_back(mk(SMUL, 1, 32'hFFFFFFFD, 32'h0,        13'h1FFB, 32'h0,        5'd4,  32'h0000000F, 32'h0,        1, 0));
    tbl.push_back(mk(SDIV, 0, 32'hFFFFFFF9, 32'h2,        13'h0,    32'hFFFFFFFF, 5'd5,  32'hFFFFFFFD, 32'h0,        0, 0));
    tbl.push_back(mk(UDIV, 0, 32'h0,        32'h1,        13'h0,    32'h1,        5'd6,  32'hFFFFFFFF, 32'h0,        0, 0));
    tbl.push_back(mk(UDIV, 0, 32'h5,        32'h0,        13'h0,    32'h0,        5'd7,  32'h0,        32'h0,        0, 1));
    tbl.push_back(mk(SMUL, 0, 32'h80000000, 32'h80000000, 13'h0,    32'h0,        5'd8,  32'h0,        32'h40000000, 1, 0));
    tbl.push_back(mk(UDIV, 1, 32'd100,      32'h0,        13'h7,    32'h0,        5'd9,  32'd14,       32'h0,        0, 0));
    tbl.push_back(mk(SDIV, 0, 32'h80000000, 32'h1,        13'h0,    32'h0,        5'd10, 32'h7FFFFFFF, 32'h0,        0, 0));
    tbl.push_back(mk(SDIV, 0, 32'h0,        32'h2,        13'h0,    32'hFFFFFFFF, 5'd11, 32'h80000000, 32'h0,        0, 0));
    tbl.push_back(mk(SDIV, 0, 32'h0,        32'h1,        13'h0,    32'hFFFFFFFF, 5'd12, 32'h80000000, 32'h0,        0, 0));
    tbl.push_back(mk(SDIV, 1, 32'd100,      32'h0,        13'h1FF9, 32'h0,        5'd13, 32'hFFFFFFF2, 32'h0,        0, 0));
    foreach (tbl[k]) do_op($sformatf("vec%0d", k), tbl[k]);

    for (int k = 0; k < 40; k++) begin
      v.op3 = (k % 4 == 0) ? UMUL : (k % 4 == 1) ? SMUL : (k % 4 == 2) ? UDIV : SDIV;
      v.i   = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom;
      v.imm = 13'($urandom);
      v.y   = ($urandom_range(0, 2) == 0) ? $urandom : 32'($signed(8'($urandom)));
      v.rd  = 5'($urandom);
      v = ref_model(v);
      do_op($sformatf("rand%0d", k), v);
    end

    // Illegal op3 is ignored.
    v = mk(6'h00, 0, 32'd3, 32'd4, 13'h0, 32'h0, 5'd1, 32'h0, 32'h0, 0, 0);
    apply(v, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("illegal_op busy", busy, 0);

    // Flush ten cycles into a UMUL; a start alongside the flush is ignored.
    v = mk(UMUL, 0, 32'd1000, 32'd1000, 13'h0, 32'h0, 5'd2, 32'd1000000, 32'h0, 1, 0);
    apply(v, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("flush busy", busy, 0);
    dseen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    chk("flush no_done", dseen, 0);
    chk("flush result_held", result, last_res);
    flush = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("flush_start busy", busy, 0);

    // Async reset mid-CALC clears everything before the next clock edge.
    apply(v, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    y_hold = '0;
    @(negedge clk);
    do_op("post_reset", mk(UMUL, 0, 32'd7, 32'd6, 13'h0, 32'h0, 5'd17, 32'd42, 32'h0, 1, 0));

    // Start held through DONE is only accepted in the following IDLE cycle.
    v = mk(UDIV, 0, 32'd81, 32'd9, 13'h0, 32'h0, 5'd21, 32'd9, 32'h0, 0, 0);
    apply(v, 1'b1);
    @(posedge clk);
    wait_done(lat, bc);
    chk("b2b first latency", lat, 34);
    @(negedge clk);
    chk("b2b idle busy", busy, 0);
    @(negedge clk);
    chk("b2b accepted busy", busy, 1);
    start = 1'b0;
    wait_done(lat, bc);
    chk("b2b second latency", lat, 33);
    check_outs("b2b", v);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
